// File: rtl/video_sync_pkg.sv
// Shared constants and types for the CRTC sync/blank conditioner.
// Channel indices fix the bit order of every 4-wide channel vector in the block.
package video_sync_pkg;
    localparam int DELAY_W_DEF = 4;
    localparam int NUM_CH      = 4;
    localparam int CH_HS       = 0;
    localparam int CH_VS       = 1;
    localparam int CH_HB       = 2;
    localparam int CH_VB       = 3;

    typedef logic [DELAY_W_DEF-1:0] dly_t;
endpackage

// File: rtl/sync_delay_line.sv
// One channel of programmable pixel delay: a shift register advanced on ce_pix,
// with a tap mux where tap 0 is the live input (zero delay, combinational).
module sync_delay_line #(
    parameter int DELAY_W = 4
) (
    input  logic               clk32,
    input  logic               reset_n,
    input  logic               ce_pix,
    input  logic               din,
    input  logic [DELAY_W-1:0] sel,
    output logic               dout
);
    localparam int MAXD = 2**DELAY_W - 1;

    logic [MAXD:1] sr_q, sr_d;
    logic [MAXD:0] tap;

    assign tap  = {sr_q, din};
    assign dout = tap[sel];

    always_comb begin
        sr_d = sr_q;
        if (ce_pix) sr_d = tap[MAXD-1:0];
    end

    always_ff @(posedge clk32 or negedge reset_n) begin
        if (!reset_n) sr_q <= '0;
        else          sr_q <= sr_d;
    end
endmodule

// File: rtl/video_sync_crtc_adj.sv
// Sync/blank conditioner: per-channel delay and polarity, optional vsync re-timing to
// the delayed hsync edge, and input line-length measurement.
module video_sync_crtc_adj
    import video_sync_pkg::*;
#(
    parameter int DELAY_W = DELAY_W_DEF,
    parameter int LEN_W   = 12
) (
    input  logic               clk32,
    input  logic               reset_n,
    input  logic               ce_pix,
    input  logic               hsync,
    input  logic               vsync,
    input  logic               hblank,
    input  logic               vblank,
    input  logic [DELAY_W-1:0] dly_hs,
    input  logic [DELAY_W-1:0] dly_vs,
    input  logic [DELAY_W-1:0] dly_hb,
    input  logic [DELAY_W-1:0] dly_vb,
    input  logic [3:0]         invert,
    input  logic               vs_align,
    output logic               hsync_out,
    output logic               vsync_out,
    output logic               hblank_out,
    output logic               vblank_out,
    output logic [LEN_W-1:0]   line_len,
    output logic               line_valid
);
    localparam logic [LEN_W-1:0] LEN_MAX = '1;

    logic [NUM_CH-1:0]              raw, chv;
    logic [NUM_CH-1:0][DELAY_W-1:0] dly_req, sh_q, sh_d;
    logic load_pend_q, load_pend_d;
    logic hs_prev_q, hs_prev_d, vb_prev_q, vb_prev_d, hsd_prev_q, hsd_prev_d;
    logic vs_hold_q, vs_hold_d;
    logic [LEN_W-1:0] cnt_q, cnt_d, line_len_q, line_len_d;
    logic line_valid_q, line_valid_d, seen_q, seen_d;
    logic hs_rise, vb_rise, hsd_rise;

    assign raw     = {vblank, hblank, vsync, hsync};
    assign dly_req = {dly_vb, dly_hb, dly_vs, dly_hs};

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        sync_delay_line #(.DELAY_W(DELAY_W)) u_dl (
            .clk32   (clk32),
            .reset_n (reset_n),
            .ce_pix  (ce_pix),
            .din     (raw[c]),
            .sel     (sh_q[c]),
            .dout    (chv[c])
        );
    end

    assign hs_rise  = raw[CH_HS] & ~hs_prev_q;
    assign vb_rise  = raw[CH_VB] & ~vb_prev_q;
    assign hsd_rise = chv[CH_HS] & ~hsd_prev_q;

    always_comb begin
        sh_d         = sh_q;
        load_pend_d  = load_pend_q;
        hs_prev_d    = hs_prev_q;
        vb_prev_d    = vb_prev_q;
        hsd_prev_d   = hsd_prev_q;
        vs_hold_d    = vs_hold_q;
        cnt_d        = cnt_q;
        line_len_d   = line_len_q;
        line_valid_d = line_valid_q;
        seen_d       = seen_q;
        if (ce_pix) begin
            load_pend_d = 1'b0;
            hs_prev_d   = raw[CH_HS];
            vb_prev_d   = raw[CH_VB];
            hsd_prev_d  = chv[CH_HS];
            // Delays switch only at frame start so a frame never mixes two settings.
            if (vb_rise || load_pend_q) sh_d = dly_req;
            if (hsd_rise) vs_hold_d = chv[CH_VS];
            if (hs_rise) begin
                line_len_d   = (cnt_q == LEN_MAX) ? LEN_MAX : cnt_q + 1'b1;
                cnt_d        = '0;
                line_valid_d = seen_q;
                seen_d       = 1'b1;
            end else begin
                if (cnt_q != LEN_MAX) cnt_d = cnt_q + 1'b1;
                // A saturated counter means the line was too long to trust.
                if (cnt_d == LEN_MAX) begin
                    line_valid_d = 1'b0;
                    seen_d       = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk32 or negedge reset_n) begin
        if (!reset_n) begin
            sh_q         <= '0;
            load_pend_q  <= 1'b1;
            hs_prev_q    <= 1'b0;
            vb_prev_q    <= 1'b0;
            hsd_prev_q   <= 1'b0;
            vs_hold_q    <= 1'b0;
            cnt_q        <= '0;
            line_len_q   <= '0;
            line_valid_q <= 1'b0;
            seen_q       <= 1'b0;
        end else begin
            sh_q         <= sh_d;
            load_pend_q  <= load_pend_d;
            hs_prev_q    <= hs_prev_d;
            vb_prev_q    <= vb_prev_d;
            hsd_prev_q   <= hsd_prev_d;
            vs_hold_q    <= vs_hold_d;
            cnt_q        <= cnt_d;
            line_len_q   <= line_len_d;
            line_valid_q <= line_valid_d;
            seen_q       <= seen_d;
        end
    end

    assign hsync_out  = chv[CH_HS] ^ invert[CH_HS];
    assign vsync_out  = (vs_align ? vs_hold_q : chv[CH_VS]) ^ invert[CH_VS];
    assign hblank_out = chv[CH_HB] ^ invert[CH_HB];
    assign vblank_out = chv[CH_VB] ^ invert[CH_VB];
    assign line_len   = line_len_q;
    assign line_valid = line_valid_q;
endmodule

// File: tb/tb_video_sync_crtc_adj.sv
// Scoreboard bench: stimulus pushes reference-model expectations, a negedge monitor compares.
// The model keeps a history of raw inputs per pixel step and measures lines by step counting.
module tb_video_sync_crtc_adj;
    localparam int DW = 4, LW = 12, MAXD = 15, LMAX = 4095;

    logic clk32 = 1'b0, reset_n = 1'b0, ce_pix = 1'b0;
    logic hsync = 1'b0, vsync = 1'b0, hblank = 1'b0, vblank = 1'b0;
    logic [DW-1:0] dly_hs = '0, dly_vs = '0, dly_hb = '0, dly_vb = '0;
    logic [3:0] invert = '0;
    logic vs_align = 1'b0;
    logic hsync_out, vsync_out, hblank_out, vblank_out, line_valid;
    logic [LW-1:0] line_len;

    video_sync_crtc_adj #(.DELAY_W(DW), .LEN_W(LW)) dut (
        .clk32(clk32), .reset_n(reset_n), .ce_pix(ce_pix),
        .hsync(hsync), .vsync(vsync), .hblank(hblank), .vblank(vblank),
        .dly_hs(dly_hs), .dly_vs(dly_vs), .dly_hb(dly_hb), .dly_vb(dly_vb),
        .invert(invert), .vs_align(vs_align),
        .hsync_out(hsync_out), .vsync_out(vsync_out), .hblank_out(hblank_out),
        .vblank_out(vblank_out), .line_len(line_len), .line_valid(line_valid)
    );

    always #5 clk32 = ~clk32;

    int checks = 0, errors = 0;
    logic [16:0] sbq[$];

    // staged configuration, applied by step() together with the inputs
    logic [DW-1:0] c_dly[4];
    logic [3:0] c_inv = '0;
    logic c_align = 1'b0;

    // stimulus generator state
    int pos = 0, P = 64, NL = 6;
    bit noise = 0, hs_kill = 0;

    // reference model state
    logic [3:0] hist[$];
    int sh[4];
    bit pend, hsd_prev, vsh, hs_prev, vb_prev, seen, lvalid;
    int since;
    logic [LW-1:0] llen;

    function automatic logic [3:0] raw_in();
        return {vblank, hblank, vsync, hsync};
    endfunction

    function automatic bit ch_val(int c);
        logic [3:0] r, h;
        r = raw_in();
        if (sh[c] == 0) return r[c];
        h = hist[sh[c]-1];
        return h[c];
    endfunction

    task automatic model_reset();
        hist.delete();
        repeat (MAXD) hist.push_back(4'b0);
        for (int c = 0; c < 4; c++) sh[c] = 0;
        pend = 1; hsd_prev = 0; vsh = 0; hs_prev = 0; vb_prev = 0;
        seen = 0; lvalid = 0; since = 0; llen = '0;
    endtask

    task automatic model_edge();
        logic [3:0] r;
        bit hsd;
        r = raw_in();
        hsd = ch_val(0);
        if (hsd && !hsd_prev) vsh = ch_val(1);
        hsd_prev = hsd;
        if ((r[3] && !vb_prev) || pend) begin
            sh[0] = int'(dly_hs); sh[1] = int'(dly_vs);
            sh[2] = int'(dly_hb); sh[3] = int'(dly_vb);
        end
        pend = 0;
        vb_prev = r[3];
        hist.push_front(r);
        void'(hist.pop_back());
        since++;
        if (r[0] && !hs_prev) begin
            llen   = (since > LMAX) ? LW'(LMAX) : LW'(since);
            lvalid = seen && (since <= LMAX);
            seen   = 1;
            since  = 0;
        end else if (since == LMAX) begin
            lvalid = 0;
            seen   = 0;
        end
        hs_prev = r[0];
    endtask

    function automatic logic [16:0] expect_out();
        logic e_hs, e_vs, e_hb, e_vb;
        e_hs = ch_val(0) ^ invert[0];
        e_vs = (vs_align ? vsh : ch_val(1)) ^ invert[1];
        e_hb = ch_val(2) ^ invert[2];
        e_vb = ch_val(3) ^ invert[3];
        return {e_hs, e_vs, e_hb, e_vb, lvalid, llen};
    endfunction

    task automatic gen_inputs();
        int x, ln;
        if (noise) begin
            hsync  = ($urandom_range(0, 3) == 0);
            vsync  = ($urandom_range(0, 1) == 0);
            hblank = ($urandom_range(0, 2) == 0);
            vblank = ($urandom_range(0, 5) == 0);
        end else begin
            x  = pos % P;
            ln = (pos / P) % NL;
            hsync  = (x < 5) && !hs_kill;
            hblank = (x < 12);
            vblank = (ln < 2);
            vsync  = (ln == 0 && x >= 10) || (ln == 1 && x < 10);
        end
    endtask

    task automatic step(input bit ce, input bit rn);
        @(posedge clk32); #1;
        if (reset_n && ce_pix) begin
            model_edge();
            pos++;
        end
        reset_n = rn;
        if (!rn) model_reset();
        ce_pix = ce;
        dly_hs = c_dly[0]; dly_vs = c_dly[1]; dly_hb = c_dly[2]; dly_vb = c_dly[3];
        invert = c_inv;
        vs_align = c_align;
        gen_inputs();
        sbq.push_back(expect_out());
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic rand_cfg();
        for (int c = 0; c < 4; c++) c_dly[c] = DW'($urandom_range(0, MAXD));
        c_inv   = 4'($urandom_range(0, 15));
        c_align = 1'($urandom_range(0, 1));
    endtask

    always @(negedge clk32) begin : mon
        logic [16:0] e, a;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            a = {hsync_out, vsync_out, hblank_out, vblank_out, line_valid, line_len};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL outputs t=%0t actual=%05h required=%05h ({hs,vs,hb,vb,valid,len})",
                         $time, a, e);
            end
        end
    end

    initial begin
        model_reset();
        for (int c = 0; c < 4; c++) c_dly[c] = 4'd3;

        // reset: pass-through, measurement cleared
        repeat (3) step(1'b1, 1'b0);
        @(negedge clk32);
        chk("rst_len", 32'(line_len), 32'd0);
        chk("rst_valid", 32'(line_valid), 32'd0);

        // delay 3 on all channels, ce_pix every 4th clock
        for (int i = 0; i < 2000; i++) step(i % 4 == 0, 1'b1);

        // shadowing: dly_hs 0->5 mid-frame, inverted syncs, ce every clock
        for (int c = 0; c < 4; c++) c_dly[c] = '0;
        c_inv = 4'b0011;
        for (int i = 0; i < 900; i++) begin
            if (i == 100) c_dly[0] = 4'd5;
            step(1'b1, 1'b1);
        end
        @(negedge clk32);
        chk("len64", 32'(line_len), 32'd64);
        chk("valid64", 32'(line_valid), 32'd1);

        // vs_align and random settings, random ce_pix
        c_align = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            if (i % 250 == 0) rand_cfg();
            step(1'($urandom_range(0, 1)), 1'b1);
        end

        // random input noise with random settings
        noise = 1;
        for (int i = 0; i < 1500; i++) begin
            if (i % 200 == 0) rand_cfg();
            step(1'($urandom_range(0, 3) != 0), 1'b1);
        end
        noise = 0; P = 64; c_align = 1'b0; c_inv = '0;

        // mid-line reset with delay 7 requested
        for (int i = 0; i < 100; i++) step(1'b1, 1'b1);
        for (int c = 0; c < 4; c++) c_dly[c] = 4'd7;
        repeat (3) step(1'b1, 1'b0);
        @(negedge clk32);
        chk("midrst_len", 32'(line_len), 32'd0);
        chk("midrst_valid", 32'(line_valid), 32'd0);
        for (int i = 0; i < 300; i++) step(1'b1, 1'b1);

        // hsync stops: counter saturates, measurement invalidated but held
        hs_kill = 1;
        for (int i = 0; i < 4200; i++) step(1'b1, 1'b1);
        @(negedge clk32);
        chk("sat_valid", 32'(line_valid), 32'd0);
        chk("sat_len_hold", 32'(line_len), 32'd64);
        hs_kill = 0;
        for (int i = 0; i < 300; i++) step(1'b1, 1'b1);

        @(negedge clk32);
        #1;
        if (sbq.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain actual=%0d required=0", sbq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
